mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage of the TINY processor: accepts one completed execute-stage operation at a time (ALU result, store data, destination register, ld/st flags), performs the data-memory read or write through a request/acknowledge handshake, and delivers a single writeback packet to the register write bank. It sits between the ALU and the register writeback and replaces direct combinational ALU-to-data-memory wiring, so variable-latency memories can stall the core via `exReady`.

## Interface
- `DATA_W`, 32, data and address width
- `REG_ADDR_W`, 4, destination register index width
- `clk`  in  1  clock; all state changes on rising edge
- `rstN`  in  1  reset, synchronous, active-low
- `exValid`  in  1  execute stage presents an operation
- `exReady`  out  1  stage can accept this cycle
- `aluResult`  in  DATA_W  effective address (ld/st) or ALU result
- `storeData`  in  DATA_W  store data (operand 2)
- `isLd`, `isSt`  in  1  load / store flags
- `isRegWritebackIn`  in  1  op writes a register
- `rdIn`  in  REG_ADDR_W  destination register
- `memReq`  out  1  data-memory request
- `memWr`  out  1  1 = write, 0 = read
- `memAddr`, `memWData`  out  DATA_W  request address / write data
- `memRData`  in  DATA_W  read data, valid with `memAck`
- `memAck`  in  1  memory completes current request
- `wbValid`  out  1  writeback packet valid (one-cycle pulse)
- `wbWrite`  out  1  register write enable
- `wbData`  out  DATA_W  writeback value
- `wbRd`  out  REG_ADDR_W  writeback register
- `misalignErr`  out  1  misaligned-access pulse (see Configuration)

## Operation
- States: IDLE, ACCESS, RESP.
- `exReady` = 1 in IDLE and RESP, 0 in ACCESS. Accept = `exValid && exReady`; op fields captured in a request register on accept.
- Non-memory op (`isLd=0, isSt=0`): accept -> RESP; `wbData=aluResult`, `wbWrite=isRegWritebackIn`.
- Load/store: accept -> ACCESS; `memReq=1`, `memAddr=aluResult`, `memWr=isSt`, `memWData=storeData`, all held stable until `memAck` sampled 1; then -> RESP.
- Load: `memRData` captured on the `memAck` edge; `wbData`=captured value, `wbWrite=1`.
- Store: `wbWrite=0`, `wbData=0`; `wbValid` still pulses (completion).
- `isLd && isSt` both set: treated as load.
- RESP: `wbValid=1` exactly one cycle. Accept in RESP follows the IDLE rules; without accept -> IDLE.
- `memAck` outside ACCESS ignored.
- Reset (`rstN=0` at an edge): state IDLE; `memReq`, `memWr`, `wbValid`, `wbWrite`, `misalignErr` = 0; `memAddr`, `memWData`, `wbData`, `wbRd` = 0. In-flight request abandoned; a later `memAck` ignored.

## Timing
- Accept at edge N: non-memory op -> `wbValid` high cycle N+1.
- Memory op -> `memReq` high from cycle N+1; `memAck` sampled high at edge M -> `memReq` low and `wbValid` high cycle M+1. Minimum ld/st latency 2 cycles (ack on first request cycle).
- Back-to-back non-memory throughput: one op per cycle.
- All outputs registered; no combinational input-to-output path except `exReady` (state-only decode).

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined: ld/st with `aluResult[1:0] != 0` skips ACCESS, goes to RESP with `wbWrite=0`, `wbData=0`, `misalignErr=1` for that RESP cycle; no `memReq` issued.
- Undefined: no check; low address bits forwarded unchanged; `misalignErr` tied 0.

## Structure
- Shared package `mem_stage_pkg`: state encoding constants (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), default widths.
- One sub-module `mem_req_reg`: request register holding address, store data, rd, op flags; load on accept, clear on reset.

## Test plan
- Non-memory: accept `aluResult=32'd42, rdIn=3, isRegWritebackIn=1` -> next cycle `wbValid=1, wbWrite=1, wbData=42, wbRd=3`; one-cycle pulse.
- Load, 3-cycle ack delay: `aluResult=32'h10`, `memAck` third ACCESS cycle with `memRData=32'hDEADBEEF` -> `memReq/memAddr=0x10` held 3 cycles, `exReady=0`, then `wbData=0xDEADBEEF, wbWrite=1`.
- Store: `aluResult=32'h20, storeData=7, isSt=1`, immediate ack -> `memWr=1, memWData=7` one cycle, then `wbValid=1, wbWrite=0`.
- Back-to-back: two ALU ops on consecutive cycles -> `wbValid` high two consecutive cycles, `exReady` stays 1.
- Reset mid-ACCESS: `rstN=0` while `memReq=1`, then `memAck=1` after release -> all outputs 0, state IDLE, no `wbValid`.
- With `MEM_MISALIGN_CHECK_EN`: load at `32'h13` -> no `memReq`, next cycle `wbValid=1, misalignErr=1, wbWrite=0`.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the memory-access stage
//
// Purpose : state encoding, default widths and the alignment helper used by
//           mem_access_stage and mem_req_reg.
// Ports   : none (package).
package mem_stage_pkg;

  localparam int DEFAULT_DATA_W     = 32;
  localparam int DEFAULT_REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } memState_t;

  // Word accesses must have the two low address bits clear.
  function automatic logic isMisaligned(input logic [1:0] lowBits);
    return |lowBits;
  endfunction

endpackage

// File: rtl/mem_req_reg.sv
// rtl/mem_req_reg.sv - request register capturing one accepted execute-stage op
//
// Purpose : holds address, store data, destination register and the load
//           flag of the operation in flight; loads on accept, clears on reset.
// Ports   : clk, rstN        clock, synchronous active-low reset
//           load             capture the *In fields this cycle
//           addrIn/dataIn    effective address / store data
//           rdIn, isLdIn     destination register / load flag
//           addr, wData, rd, isLd  registered copies
module mem_req_reg
  import mem_stage_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  load,
  input  logic [DATA_W-1:0]     addrIn,
  input  logic [DATA_W-1:0]     dataIn,
  input  logic [REG_ADDR_W-1:0] rdIn,
  input  logic                  isLdIn,
  output logic [DATA_W-1:0]     addr,
  output logic [DATA_W-1:0]     wData,
  output logic [REG_ADDR_W-1:0] rd,
  output logic                  isLd
);

  always_ff @(posedge clk) begin
    if (!rstN) begin
      addr  <= '0;
      wData <= '0;
      rd    <= '0;
      isLd  <= 1'b0;
    end else if (load) begin
      addr  <= addrIn;
      wData <= dataIn;
      rd    <= rdIn;
      isLd  <= isLdIn;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - TINY memory-access stage with req/ack data-memory port
//
// Purpose : accepts one execute-stage op at a time, performs the data-memory
//           read/write through a request/acknowledge handshake and emits one
//           writeback packet per op.
// Config  : MEM_MISALIGN_CHECK_EN - when defined, ld/st to an address with
//           non-zero low two bits bypass memory and report misalignErr.
// Ports   : clk, rstN                   clock, synchronous active-low reset
//           exValid/exReady             execute-stage handshake
//           aluResult, storeData        address or ALU result / store data
//           isLd, isSt, isRegWritebackIn, rdIn   op flags and destination
//           memReq, memWr, memAddr, memWData      data-memory request
//           memRData, memAck            data-memory response
//           wbValid, wbWrite, wbData, wbRd        writeback packet
//           misalignErr                 misaligned-access pulse
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  exValid,
  output logic                  exReady,
  input  logic [DATA_W-1:0]     aluResult,
  input  logic [DATA_W-1:0]     storeData,
  input  logic                  isLd,
  input  logic                  isSt,
  input  logic                  isRegWritebackIn,
  input  logic [REG_ADDR_W-1:0] rdIn,
  output logic                  memReq,
  output logic                  memWr,
  output logic [DATA_W-1:0]     memAddr,
  output logic [DATA_W-1:0]     memWData,
  input  logic [DATA_W-1:0]     memRData,
  input  logic                  memAck,
  output logic                  wbValid,
  output logic                  wbWrite,
  output logic [DATA_W-1:0]     wbData,
  output logic [REG_ADDR_W-1:0] wbRd,
  output logic                  misalignErr
);

  memState_t             state;
  logic                  accept;
  logic                  isMemOp;
  logic                  misaligned;
  logic [REG_ADDR_W-1:0] reqRd;
  logic                  reqIsLd;

  // State-only decode: the one permitted combinational output.
  assign exReady = (state != ACCESS);
  assign accept  = exValid && exReady;
  assign isMemOp = isLd || isSt;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = isMemOp && isMisaligned(aluResult[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  // Address and store data come straight from the request register; they
  // only change on accept, so they stay stable for the whole ACCESS phase.
  mem_req_reg #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) reqReg (
    .clk    (clk),
    .rstN   (rstN),
    .load   (accept),
    .addrIn (aluResult),
    .dataIn (storeData),
    .rdIn   (rdIn),
    .isLdIn (isLd),
    .addr   (memAddr),
    .wData  (memWData),
    .rd     (reqRd),
    .isLd   (reqIsLd)
  );

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state       <= IDLE;
      memReq      <= 1'b0;
      memWr       <= 1'b0;
      wbValid     <= 1'b0;
      wbWrite     <= 1'b0;
      wbData      <= '0;
      wbRd        <= '0;
      misalignErr <= 1'b0;
    end else begin
      // Writeback qualifiers are pulses; data/rd simply hold.
      wbValid     <= 1'b0;
      wbWrite     <= 1'b0;
      misalignErr <= 1'b0;
      case (state)
        ACCESS: begin
          if (memAck) begin
            state   <= RESP;
            memReq  <= 1'b0;
            memWr   <= 1'b0;
            wbValid <= 1'b1;
            wbRd    <= reqRd;
            // ld+st together is a load, so reqIsLd alone decides.
            wbWrite <= reqIsLd;
            wbData  <= reqIsLd ? memRData : '0;
          end
        end
        default: begin  // IDLE and RESP share the accept rules
          if (!accept) begin
            state <= IDLE;
          end else if (misaligned) begin
            state       <= RESP;
            wbValid     <= 1'b1;
            wbData      <= '0;
            wbRd        <= rdIn;
            misalignErr <= 1'b1;
          end else if (isMemOp) begin
            state  <= ACCESS;
            memReq <= 1'b1;
            memWr  <= isSt && !isLd;
          end else begin
            state   <= RESP;
            wbValid <= 1'b1;
            wbWrite <= isRegWritebackIn;
            wbData  <= aluResult;
            wbRd    <= rdIn;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rstN;
  logic        exValid;
  logic        exReady;
  logic [31:0] aluResult;
  logic [31:0] storeData;
  logic        isLd;
  logic        isSt;
  logic        isRegWritebackIn;
  logic [3:0]  rdIn;
  logic        memReq;
  logic        memWr;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [31:0] memRData;
  logic        memAck;
  logic        wbValid;
  logic        wbWrite;
  logic [31:0] wbData;
  logic [3:0]  wbRd;
  logic        misalignErr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(32), .REG_ADDR_W(4)) dut (
    .clk              (clk),
    .rstN             (rstN),
    .exValid          (exValid),
    .exReady          (exReady),
    .aluResult        (aluResult),
    .storeData        (storeData),
    .isLd             (isLd),
    .isSt             (isSt),
    .isRegWritebackIn (isRegWritebackIn),
    .rdIn             (rdIn),
    .memReq           (memReq),
    .memWr            (memWr),
    .memAddr          (memAddr),
    .memWData         (memWData),
    .memRData         (memRData),
    .memAck           (memAck),
    .wbValid          (wbValid),
    .wbWrite          (wbWrite),
    .wbData           (wbData),
    .wbRd             (wbRd),
    .misalignErr      (misalignErr)
  );

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] s,
                       input logic ld, input logic st, input logic wb, input logic [3:0] rd);
    exValid = v; aluResult = a; storeData = s; isLd = ld; isSt = st;
    isRegWritebackIn = wb; rdIn = rd;
  endtask

  task automatic test_reset();
    rstN = 1'b0; memAck = 1'b0; memRData = '0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    step(); step();
    checks++;
    if ({exReady, memReq, memWr, wbValid, wbWrite, misalignErr} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags got %b want %b", {exReady, memReq, memWr, wbValid, wbWrite, misalignErr}, 6'b100000);
    end
    checks++;
    if ({memAddr, memWData, wbData, wbRd} !== 100'd0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h %h want all zero", memAddr, memWData, wbData, wbRd);
    end
    rstN = 1'b1;
  endtask

  task automatic test_alu_op();
    drive(1'b1, 32'd42, 32'd0, 1'b0, 1'b0, 1'b1, 4'd3);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    checks++;
    if ({wbValid, wbWrite, wbData, wbRd, memReq} !== {1'b1, 1'b1, 32'd42, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL alu_wb got v=%b w=%b d=%h rd=%h req=%b want 1 1 0000002a 3 0", wbValid, wbWrite, wbData, wbRd, memReq);
    end
    step();
    checks++;
    if (wbValid !== 1'b0) begin
      errors++;
      $display("FAIL alu_pulse got wbValid=%b want 0", wbValid);
    end
  endtask

  task automatic test_load_delay();
    drive(1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 4'd5);
    step();
    // Op attempted during ACCESS must be ignored.
    drive(1'b1, 32'h99, 32'h0, 1'b0, 1'b0, 1'b1, 4'd9);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({memReq, memWr, memAddr, exReady, wbValid} !== {1'b1, 1'b0, 32'h10, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL load_access%0d got req=%b wr=%b addr=%h rdy=%b v=%b want 1 0 00000010 0 0", i, memReq, memWr, memAddr, exReady, wbValid);
      end
      if (i == 2) begin
        memAck = 1'b1; memRData = 32'hDEADBEEF;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
      end
      step();
    end
    memAck = 1'b0; memRData = '0;
    checks++;
    if ({memReq, wbValid, wbWrite, wbData, wbRd} !== {1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 4'd5}) begin
      errors++;
      $display("FAIL load_wb got req=%b v=%b w=%b d=%h rd=%h want 0 1 1 deadbeef 5", memReq, wbValid, wbWrite, wbData, wbRd);
    end
    step();
    checks++;
    if ({wbValid, exReady} !== 2'b01) begin
      errors++;
      $display("FAIL load_done got v=%b rdy=%b want 0 1", wbValid, exReady);
    end
  endtask

  task automatic test_store();
    drive(1'b1, 32'h20, 32'd7, 1'b0, 1'b1, 1'b0, 4'd0);
    step();
    checks++;
    if ({memReq, memWr, memAddr, memWData} !== {1'b1, 1'b1, 32'h20, 32'd7}) begin
      errors++;
      $display("FAIL store_req got req=%b wr=%b addr=%h wd=%h want 1 1 00000020 00000007", memReq, memWr, memAddr, memWData);
    end
    memAck = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    memAck = 1'b0;
    checks++;
    if ({memReq, memWr, wbValid, wbWrite, wbData} !== {1'b0, 1'b0, 1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL store_wb got req=%b wr=%b v=%b w=%b d=%h want 0 0 1 0 00000000", memReq, memWr, wbValid, wbWrite, wbData);
    end
    step();
  endtask

  task automatic test_ld_and_st();
    drive(1'b1, 32'h30, 32'h77, 1'b1, 1'b1, 1'b0, 4'd4);
    step();
    checks++;
    if ({memReq, memWr} !== 2'b10) begin
      errors++;
      $display("FAIL ldst_req got req=%b wr=%b want 1 0", memReq, memWr);
    end
    memAck = 1'b1; memRData = 32'h55;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    memAck = 1'b0; memRData = '0;
    checks++;
    if ({wbValid, wbWrite, wbData, wbRd} !== {1'b1, 1'b1, 32'h55, 4'd4}) begin
      errors++;
      $display("FAIL ldst_wb got v=%b w=%b d=%h rd=%h want 1 1 00000055 4", wbValid, wbWrite, wbData, wbRd);
    end
    step();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'd100, 32'd0, 1'b0, 1'b0, 1'b1, 4'd1);
    step();
    checks++;
    if ({wbValid, wbWrite, wbData, wbRd, exReady} !== {1'b1, 1'b1, 32'd100, 4'd1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_first got v=%b w=%b d=%h rd=%h rdy=%b want 1 1 00000064 1 1", wbValid, wbWrite, wbData, wbRd, exReady);
    end
    drive(1'b1, 32'd200, 32'd0, 1'b0, 1'b0, 1'b0, 4'd2);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    checks++;
    if ({wbValid, wbWrite, wbData, wbRd, exReady} !== {1'b1, 1'b0, 32'd200, 4'd2, 1'b1}) begin
      errors++;
      $display("FAIL b2b_second got v=%b w=%b d=%h rd=%h rdy=%b want 1 0 000000c8 2 1", wbValid, wbWrite, wbData, wbRd, exReady);
    end
    step();
    checks++;
    if (wbValid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got wbValid=%b want 0", wbValid);
    end
  endtask

  task automatic test_ack_outside_access();
    memAck = 1'b1; memRData = 32'hBAD;
    step(); step();
    memAck = 1'b0; memRData = '0;
    checks++;
    if ({memReq, wbValid, exReady} !== 3'b001) begin
      errors++;
      $display("FAIL stray_ack got req=%b v=%b rdy=%b want 0 0 1", memReq, wbValid, exReady);
    end
  endtask

  task automatic test_reset_mid_access();
    drive(1'b1, 32'h40, 32'h0, 1'b1, 1'b0, 1'b1, 4'd7);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    checks++;
    if (memReq !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_req got req=%b want 1", memReq);
    end
    rstN = 1'b0;
    step();
    rstN = 1'b1;
    checks++;
    if ({exReady, memReq, memWr, wbValid, wbWrite, misalignErr, memAddr, wbData, wbRd} !== {6'b100000, 32'd0, 32'd0, 4'd0}) begin
      errors++;
      $display("FAIL rst_mid_state got rdy=%b req=%b v=%b addr=%h d=%h rd=%h want 1 0 0 0 0 0", exReady, memReq, wbValid, memAddr, wbData, wbRd);
    end
    memAck = 1'b1; memRData = 32'h1234;
    step();
    memAck = 1'b0; memRData = '0;
    step();
    checks++;
    if ({memReq, wbValid, wbData} !== {1'b0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL rst_late_ack got req=%b v=%b d=%h want 0 0 00000000", memReq, wbValid, wbData);
    end
  endtask

  task automatic test_misalign();
    drive(1'b1, 32'h13, 32'h0, 1'b1, 1'b0, 1'b1, 4'd6);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
`ifdef MEM_MISALIGN_CHECK_EN
    checks++;
    if ({memReq, wbValid, misalignErr, wbWrite, wbData} !== {1'b0, 1'b1, 1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL misalign_resp got req=%b v=%b err=%b w=%b d=%h want 0 1 1 0 00000000", memReq, wbValid, misalignErr, wbWrite, wbData);
    end
    step();
    checks++;
    if ({wbValid, misalignErr, memReq} !== 3'b000) begin
      errors++;
      $display("FAIL misalign_end got v=%b err=%b req=%b want 0 0 0", wbValid, misalignErr, memReq);
    end
`else
    checks++;
    if ({memReq, memAddr, misalignErr} !== {1'b1, 32'h13, 1'b0}) begin
      errors++;
      $display("FAIL unaligned_req got req=%b addr=%h err=%b want 1 00000013 0", memReq, memAddr, misalignErr);
    end
    memAck = 1'b1; memRData = 32'hA5;
    step();
    memAck = 1'b0; memRData = '0;
    checks++;
    if ({wbValid, wbWrite, wbData, misalignErr} !== {1'b1, 1'b1, 32'hA5, 1'b0}) begin
      errors++;
      $display("FAIL unaligned_wb got v=%b w=%b d=%h err=%b want 1 1 000000a5 0", wbValid, wbWrite, wbData, misalignErr);
    end
    step();
`endif
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load_delay();
    test_store();
    test_ld_and_st();
    test_back_to_back();
    test_ack_outside_access();
    test_reset_mid_access();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
